// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one spi_master byte engine between NUM_REQ requesters.
// Sequences the master's start/done handshake, decodes CS per slave and aborts hung transfers.
module spi_req_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int SLV_W   = 2,
    parameter  int TIMEOUT = 64,
    localparam int NUM_SLV = 2 ** SLV_W,
    localparam int GW      = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [8*NUM_REQ-1:0]     req_data,
    input  logic [NUM_REQ-1:0]       req_mode,
    input  logic [SLV_W*NUM_REQ-1:0] req_slave,
    output logic [NUM_REQ-1:0]       ack,
    output logic [7:0]               rsp_data,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [GW-1:0]            grant_id,
    output logic                     m_start,
    output logic [7:0]               m_data_in,
    output logic                     m_mode,
    input  logic                     m_cs,
    input  logic                     m_done,
    input  logic [7:0]               m_data_out,
    output logic [NUM_SLV-1:0]       ss_n
);

    localparam int WDW = $clog2(TIMEOUT) + 1;
    // The watchdog lands on TIMEOUT-1 on the same edge that enters RESP.
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_ACC,
        BUSY,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [GW-1:0]    rr_ptr;
    logic [GW-1:0]    pick;
    logic [GW-1:0]    idx;
    logic             found;
    logic             take_grant;
    logic             done_hit;
    logic             timeout_hit;
    logic [SLV_W-1:0] lat_slave;
    logic [WDW-1:0]   wd;

    logic [7:0]       data_arr  [NUM_REQ];
    logic [SLV_W-1:0] slave_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i]  = req_data[8*i +: 8];
        assign slave_arr[i] = req_slave[SLV_W*i +: SLV_W];
    end

    // First asserted request at or above the rr pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = GW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign take_grant = (state == IDLE) && found && m_cs;

    always_comb begin
        state_next  = state;
        done_hit    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (take_grant) state_next = START;
            end
            START: state_next = WAIT_ACC;
            WAIT_ACC: begin
                if (wd == WD_LAST) begin
                    state_next  = RESP;
                    timeout_hit = 1'b1;
                end else if (!m_cs) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (m_cs && m_done) begin
                    state_next = RESP;
                    done_hit   = 1'b1;
                end else if (wd == WD_LAST) begin
                    state_next  = RESP;
                    timeout_hit = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            wd    <= '0;
        end else begin
            state <= state_next;
            if (state == START) begin
                wd <= '0;
            end else if (state == WAIT_ACC || state == BUSY) begin
                wd <= wd + 1'b1;
            end
        end
    end

    // Grant-time latches; m_data_in/m_mode keep their value until the next grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            grant_id  <= '0;
            lat_slave <= '0;
            m_data_in <= '0;
            m_mode    <= 1'b0;
        end else if (take_grant) begin
            rr_ptr    <= GW'((int'(pick) + 1) % NUM_REQ);
            grant_id  <= pick;
            lat_slave <= slave_arr[pick];
            m_data_in <= data_arr[pick];
            m_mode    <= req_mode[pick];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (done_hit) begin
            rsp_data <= m_data_out;
            rsp_err  <= 1'b0;
        end else if (timeout_hit) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
        end
    end

    assign m_start = (state == START);
    assign busy    = (state != IDLE);

    always_comb begin
        ack = '0;
        if (state == RESP) ack[grant_id] = 1'b1;
    end

    always_comb begin
        ss_n = '1;
        if ((state == WAIT_ACC || state == BUSY) && !m_cs) ss_n[lat_slave] = 1'b0;
    end

endmodule
